wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  Writeback stage of the 5-stage pipeline. Registers MEM-stage results and picks ALU result or load data.
//  Byte-aligns and sign/zero-extends load data.
//  Drives the regfile write port (wb_rf_we/waddr/wdata) consumed by the decode stage's regfile and write-first bypass.
//  Captures synchronous data-RAM read data so loads survive pipeline stalls.
// PARAMETERS
//  RESET_PC   32'hbfc0_0000   value of wb_pc_o while the stage holds no valid instruction after reset
// PORTS
//  clk               in   1   core clock, all state on rising edge
//  rst               in   1   synchronous reset, active-low
//  stall_i           in   1   hold WB contents (stage does not advance)
//  flush_i           in   1   kill current WB contents (exception/redirect)
//  mem_valid_i       in   1   MEM stage holds a valid instruction
//  mem_pc_i          in   32  PC of MEM instruction
//  mem_rf_we_i       in   1   instruction writes a GPR
//  mem_rf_waddr_i    in   5   destination GPR (`RegAddrBus)
//  mem_alu_res_i     in   32  ALU result / effective address (`RegBus)
//  mem_sel_rf_res_i  in   1   1 = write load data, 0 = write ALU result
//  mem_load_op_i     in   3   load type: see BEHAVIOUR
//  data_ram_rdata_i  in   32  data SRAM read word, valid exactly one cycle after MEM-stage request
//  wb_rf_we          out  1   regfile write enable
//  wb_rf_waddr       out  5   regfile write address
//  wb_rf_wdata       out  32  regfile write data
//  wb_pc_o           out  32  PC of instruction in WB
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): valid<=0, hold_vld<=0, all stage regs <=0, pc reg <=RESET_PC.
//    wb_rf_we=0 and wb_rf_waddr=0 the cycle after reset.
//  - Advance priority each edge: reset > flush_i > stall_i > load.
//    flush: valid<=0, hold_vld<=0.
//    stall: all regs hold.
//    else: latch all mem_* inputs; valid<=mem_valid_i; hold_vld<=0.
//  - Flush while stalled: flush wins. Instruction is killed and no further write is issued.
//  - Latency: a MEM instruction appears on the wb_rf_* outputs the cycle after it is latched.
//    Outputs are combinational from stage regs, so the decode stage sees a same-cycle bypass.
//  - wb_rf_we = valid & rf_we & (waddr != 0). GPR0 writes are suppressed.
//    Not gated by stall_i: repeated writes during a stall are idempotent by design.
//  - Load data source: first WB cycle uses data_ram_rdata_i.
//    If stall_i is high in a cycle where valid & sel_rf_res & !hold_vld: rdata_hold<=data_ram_rdata_i, hold_vld<=1.
//    While hold_vld==1, rdata_hold is used instead of data_ram_rdata_i. hold_vld clears on advance or flush.
//  - Load align on addr_lo = alu_res[1:0], little-endian (lane0 = bits 7:0):
//    000 LW  : full word, addr_lo ignored
//    001 LB  : byte[addr_lo], sign-extend
//    010 LBU : byte[addr_lo], zero-extend
//    011 LH  : half[addr_lo[1]], sign-extend; addr_lo[0] ignored (misalign trapped upstream)
//    100 LHU : half[addr_lo[1]], zero-extend
//    101-111 : treated as LW
//  - wb_rf_wdata = sel_rf_res ? aligned_load : alu_res.
//  - wb_pc_o = registered PC. Invalid slot keeps last PC (RESET_PC after reset).
// CONFIGURATION
//  WB_DEBUG_TRACE_EN defined: extra outputs for the commit-trace comparator:
//    debug_wb_pc[31:0], debug_wb_rf_wen[3:0], debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0].
//    debug_wb_rf_wen = {4{wb_rf_we & first_cycle}}, where first_cycle = 1 only on the first cycle an
//    instruction occupies WB, so each commit is reported once even under stall.
//    All debug outputs are 0 in reset.
//  Undefined: ports and first_cycle flop are absent; functional behaviour is identical.
// STRUCTURE
//  Shared header lib/defines.vh: `RegAddrBus, `RegBus, load-op codes `LOAD_LW/LB/LBU/LH/LHU (3-bit).
//  One sub-module: wb_load_align (combinational). Inputs rdata[31:0], addr_lo[1:0], load_op[2:0];
//  output wdata[31:0]. Stage regs and the hold buffer stay in wb_stage.
// TESTING
//  1 Reset: hold rst=0 two cycles with mem_* active -> wb_rf_we=0, wb_pc_o=RESET_PC; first edge after release latches MEM.
//  2 ALU writeback: mem rf_we=1, waddr=5, alu_res=32'h1234_5678, sel=0 -> next cycle we=1, waddr=5, wdata=32'h1234_5678.
//  3 Load align: rdata=32'h80F1_7F02, addr_lo=3, LB -> 32'hFFFF_FF80; LBU -> 32'h0000_0080.
//    LH addr_lo=2 -> 32'hFFFF_80F1; LHU addr_lo=0 -> 32'h0000_7F02.
//  4 Stall on load: LW enters WB, rdata=32'hCAFE_F00D, stall_i=1 for 3 cycles while rdata_i changes to 0
//    -> wdata stays 32'hCAFE_F00D all 3 cycles; trace wen pulses once (WB_DEBUG_TRACE_EN).
//  5 GPR0 and flush: waddr=0 with rf_we=1 -> we=0. Flush asserted with stall_i=1 -> next cycle we=0, hold_vld=0.
//  6 Back-to-back: three consecutive writes to r7 (values 1,2,3) -> wb_rf_wdata 1,2,3 on successive cycles, no bubbles.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and load-op encodings for the writeback stage.
package wb_stage_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 5;

  localparam logic [2:0] LOAD_LW  = 3'b000;
  localparam logic [2:0] LOAD_LB  = 3'b001;
  localparam logic [2:0] LOAD_LBU = 3'b010;
  localparam logic [2:0] LOAD_LH  = 3'b011;
  localparam logic [2:0] LOAD_LHU = 3'b100;

  // Everything latched from MEM when the stage advances.
  typedef struct packed {
    logic [REG_W-1:0]  pc;
    logic              rf_we;
    logic [ADDR_W-1:0] waddr;
    logic [REG_W-1:0]  alu_res;
    logic              sel_rf_res;
    logic [2:0]        load_op;
  } wb_regs_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks byte/half lane by address and extends.
// Unknown load-op codes fall back to a full-word load.
module wb_load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_op,
  output logic [31:0] wdata
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select (little-endian) and sign/zero extension.
  always_comb begin
    wdata     = rdata;
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    // addr_lo[0] is ignored for halves; misalignment traps before WB.
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (load_op)
      LOAD_LB:  wdata = {{24{byte_lane[7]}}, byte_lane};
      LOAD_LBU: wdata = {24'h0, byte_lane};
      LOAD_LH:  wdata = {{16{half_lane[15]}}, half_lane};
      LOAD_LHU: wdata = {16'h0, half_lane};
      default:  wdata = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM results, aligns load data, drives the
// regfile write port. Synchronous RAM read data is captured into a hold
// buffer when a load stalls in WB so it survives the stall.
// Optional commit-trace outputs are enabled with WB_DEBUG_TRACE_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_rf_we_i,
  input  logic [4:0]  mem_rf_waddr_i,
  input  logic [31:0] mem_alu_res_i,
  input  logic        mem_sel_rf_res_i,
  input  logic [2:0]  mem_load_op_i,
  input  logic [31:0] data_ram_rdata_i,
`ifdef WB_DEBUG_TRACE_EN
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
`endif
  output logic        wb_rf_we,
  output logic [4:0]  wb_rf_waddr,
  output logic [31:0] wb_rf_wdata,
  output logic [31:0] wb_pc_o
);

  wb_regs_t    regs;
  logic        valid;
  logic        hold_vld;
  logic [31:0] rdata_hold;
  logic [31:0] load_src;
  logic [31:0] load_data;

  // Stage registers: reset > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs       <= '0;
      regs.pc    <= RESET_PC;
      valid      <= 1'b0;
      hold_vld   <= 1'b0;
      rdata_hold <= '0;
    end else if (flush_i) begin
      valid    <= 1'b0;
      hold_vld <= 1'b0;
    end else if (stall_i) begin
      // RAM data is only valid on the first WB cycle; keep a copy.
      if (valid && regs.sel_rf_res && !hold_vld) begin
        rdata_hold <= data_ram_rdata_i;
        hold_vld   <= 1'b1;
      end
    end else begin
      regs.pc         <= mem_pc_i;
      regs.rf_we      <= mem_rf_we_i;
      regs.waddr      <= mem_rf_waddr_i;
      regs.alu_res    <= mem_alu_res_i;
      regs.sel_rf_res <= mem_sel_rf_res_i;
      regs.load_op    <= mem_load_op_i;
      valid           <= mem_valid_i;
      hold_vld        <= 1'b0;
    end
  end

  assign load_src = hold_vld ? rdata_hold : data_ram_rdata_i;

  wb_load_align u_align (
    .rdata   (load_src),
    .addr_lo (regs.alu_res[1:0]),
    .load_op (regs.load_op),
    .wdata   (load_data)
  );

  // Not gated by stall: repeated identical writes are harmless.
  assign wb_rf_we    = valid & regs.rf_we & (regs.waddr != 5'd0);
  assign wb_rf_waddr = regs.waddr;
  assign wb_rf_wdata = regs.sel_rf_res ? load_data : regs.alu_res;
  assign wb_pc_o     = regs.pc;

`ifdef WB_DEBUG_TRACE_EN
  logic first_cycle;

  // Marks the first cycle an instruction sits in WB so a stalled commit is reported once.
  always_ff @(posedge clk) begin
    if (!rst)         first_cycle <= 1'b0;
    else if (flush_i) first_cycle <= 1'b0;
    else if (stall_i) first_cycle <= 1'b0;
    else              first_cycle <= mem_valid_i;
  end

  assign debug_wb_pc       = valid ? regs.pc : 32'h0;
  assign debug_wb_rf_wen   = {4{wb_rf_we & first_cycle}};
  assign debug_wb_rf_wnum  = valid ? regs.waddr : 5'h0;
  assign debug_wb_rf_wdata = valid ? wb_rf_wdata : 32'h0;
`endif

endmodule
